// File: rtl/draw_compositor.sv
// N-channel pixel compositor: packet-locked arbitration, colour-key transparency and
// screen clipping in front of the VGA write port. Optional counters: DRAW_COMPOSITOR_STATS_EN.
module draw_compositor #(
  parameter int unsigned    NUM_CH          = 4,
  parameter int unsigned    XW              = 9,
  parameter int unsigned    YW              = 8,
  parameter int unsigned    CW              = 12,
  parameter int unsigned    SCREEN_W        = 320,
  parameter int unsigned    SCREEN_H        = 240,
  parameter logic [CW-1:0]  TRANSPARENT_KEY = '0
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   rr_mode,
  input  logic [NUM_CH-1:0]      key_en,
  input  logic [NUM_CH-1:0]      ch_valid,
  input  logic [NUM_CH-1:0]      ch_last,
  input  logic [NUM_CH*XW-1:0]   ch_x,
  input  logic [NUM_CH*YW-1:0]   ch_y,
  input  logic [NUM_CH*CW-1:0]   ch_color,
  output logic [NUM_CH-1:0]      ch_ready,
  output logic [NUM_CH-1:0]      ch_done,
  output logic [XW-1:0]          X_out,
  output logic [YW-1:0]          Y_out,
  output logic [CW-1:0]          Color_out,
  output logic                   writeEn,
  output logic                   busy,
`ifdef DRAW_COMPOSITOR_STATS_EN
  input  logic                   clear_stats,
  output logic [15:0]            pix_written,
  output logic [15:0]            pix_suppressed,
`endif
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] grant_id
);

  localparam int unsigned GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  typedef logic [GW-1:0] gid_t;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    STREAM
  } state_t;

  state_t            state, state_nxt;
  gid_t              rr_ptr;
  gid_t              base;
  gid_t              win_id;
  logic              win_found;
  int unsigned       win_off;
  int unsigned       win_sum;
  logic [2*NUM_CH-1:0] dbl_valid;

  logic              sel_valid;
  logic              sel_last;
  logic              sel_key;
  logic [XW-1:0]     sel_x;
  logic [YW-1:0]     sel_y;
  logic [CW-1:0]     sel_c;
  logic              beat;
  logic              suppress;

  // Arbiter: rotating a doubled request vector by the base pointer turns
  // round-robin into a plain first-set search; fixed priority uses base 0.
  always_comb begin
    base      = rr_mode ? rr_ptr : '0;
    dbl_valid = {ch_valid, ch_valid} >> base;
    win_found = 1'b0;
    win_off   = 0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (!win_found && dbl_valid[k]) begin
        win_found = 1'b1;
        win_off   = k;
      end
    end
    win_sum = 32'(base) + win_off;
    if (win_sum >= NUM_CH)
      win_sum = win_sum - NUM_CH;
    win_id = gid_t'(win_sum);
  end

  // Granted-channel mux
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_key   = 1'b0;
    sel_x     = '0;
    sel_y     = '0;
    sel_c     = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (gid_t'(i) == grant_id) begin
        sel_valid = ch_valid[i];
        sel_last  = ch_last[i];
        sel_key   = key_en[i];
        sel_x     = ch_x[i*XW +: XW];
        sel_y     = ch_y[i*YW +: YW];
        sel_c     = ch_color[i*CW +: CW];
      end
    end
  end

  assign beat     = (state == STREAM) && sel_valid;
  assign suppress = (sel_key && (sel_c == TRANSPARENT_KEY)) ||
                    (32'(sel_x) >= SCREEN_W) ||
                    (32'(sel_y) >= SCREEN_H);

  // State register
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (win_found) state_nxt = GRANT;
      GRANT:   state_nxt = STREAM;
      STREAM:  if (beat && sel_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    busy     = (state != IDLE);
    ch_ready = '0;
    for (int unsigned i = 0; i < NUM_CH; i++)
      ch_ready[i] = (state == STREAM) && (gid_t'(i) == grant_id);
  end

  // Grant and round-robin pointer
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      grant_id <= '0;
      rr_ptr   <= '0;
    end else begin
      if (state == IDLE && win_found)
        grant_id <= win_id;
      if (beat && sel_last)
        rr_ptr <= (32'(grant_id) + 1 >= NUM_CH) ? '0 : gid_t'(32'(grant_id) + 1);
    end
  end

  // Pixel output register; suppressed beats still update coordinates and colour
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      X_out     <= '0;
      Y_out     <= '0;
      Color_out <= '0;
      writeEn   <= 1'b0;
      ch_done   <= '0;
    end else begin
      writeEn <= beat && !suppress;
      ch_done <= (beat && sel_last) ? ch_ready : '0;
      if (beat) begin
        X_out     <= sel_x;
        Y_out     <= sel_y;
        Color_out <= sel_c;
      end
    end
  end

`ifdef DRAW_COMPOSITOR_STATS_EN
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      pix_written    <= '0;
      pix_suppressed <= '0;
    end else if (clear_stats) begin
      pix_written    <= '0;
      pix_suppressed <= '0;
    end else if (beat) begin
      if (suppress) begin
        if (pix_suppressed != '1)
          pix_suppressed <= pix_suppressed + 16'd1;
      end else begin
        if (pix_written != '1)
          pix_written <= pix_written + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_draw_compositor.sv
// Directed self-checking bench for draw_compositor: arbitration, transparency,
// clipping, stall and mid-packet reset; counters when DRAW_COMPOSITOR_STATS_EN is set.
module tb_draw_compositor;

  logic        clk;
  logic        resetn;
  logic        rr_mode;
  logic [3:0]  key_en;
  logic [3:0]  ch_valid;
  logic [3:0]  ch_last;
  logic [35:0] ch_x;
  logic [31:0] ch_y;
  logic [47:0] ch_color;
  logic [3:0]  ch_ready;
  logic [3:0]  ch_done;
  logic [8:0]  X_out;
  logic [7:0]  Y_out;
  logic [11:0] Color_out;
  logic        writeEn;
  logic        busy;
  logic [1:0]  grant_id;
`ifdef DRAW_COMPOSITOR_STATS_EN
  logic        clear_stats;
  logic [15:0] pix_written;
  logic [15:0] pix_suppressed;
`endif

  draw_compositor #(.NUM_CH(4), .XW(9), .YW(8), .CW(12)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .rr_mode   (rr_mode),
    .key_en    (key_en),
    .ch_valid  (ch_valid),
    .ch_last   (ch_last),
    .ch_x      (ch_x),
    .ch_y      (ch_y),
    .ch_color  (ch_color),
    .ch_ready  (ch_ready),
    .ch_done   (ch_done),
    .X_out     (X_out),
    .Y_out     (Y_out),
    .Color_out (Color_out),
    .writeEn   (writeEn),
    .busy      (busy),
`ifdef DRAW_COMPOSITOR_STATS_EN
    .clear_stats    (clear_stats),
    .pix_written    (pix_written),
    .pix_suppressed (pix_suppressed),
`endif
    .grant_id  (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Per-channel beat tables driven through a valid/ready source model
  logic [8:0]  bx [4][8];
  logic [7:0]  by [4][8];
  logic [11:0] bc [4][8];
  logic        bl [4][8];
  int          len [4];
  int          pos [4];
  logic [3:0]  stall;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      if (pos[i] < len[i] && !stall[i]) begin
        ch_valid[i]          = 1'b1;
        ch_last[i]           = bl[i][pos[i]];
        ch_x[i*9 +: 9]       = bx[i][pos[i]];
        ch_y[i*8 +: 8]       = by[i][pos[i]];
        ch_color[i*12 +: 12] = bc[i][pos[i]];
      end else begin
        ch_valid[i] = 1'b0;
        ch_last[i]  = 1'b0;
      end
    end
  endtask

  task automatic load(input int ch, input int b, input int x, input int y,
                      input logic [11:0] c, input logic last);
    bx[ch][b] = 9'(x);
    by[ch][b] = 8'(y);
    bc[ch][b] = c;
    bl[ch][b] = last;
    if (len[ch] < b + 1) len[ch] = b + 1;
  endtask

  task automatic cyc();
    logic [3:0] acc;
    acc = ch_valid & ch_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      if (acc[i]) pos[i]++;
    drive();
  endtask

  task automatic do_reset();
    resetn = 1'b1;
    stall  = '0;
    for (int i = 0; i < 4; i++) begin
      len[i] = 0;
      pos[i] = 0;
    end
    drive();
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    resetn = 1'b0;
  endtask

  int we_fp [10] = '{0, 0, 1, 1, 1, 0, 0, 1, 1, 1};
  int rr_exp [5] = '{0, 1, 2, 3, 0};

  initial begin
    rr_mode  = 1'b0;
    key_en   = '0;
    ch_valid = '0;
    ch_last  = '0;
    ch_x     = '0;
    ch_y     = '0;
    ch_color = '0;
`ifdef DRAW_COMPOSITOR_STATS_EN
    clear_stats = 1'b0;
`endif
    resetn = 1'b1;
    stall  = '0;
    for (int i = 0; i < 4; i++) begin
      len[i] = 0;
      pos[i] = 0;
    end
    @(posedge clk);
    #1;
    check("rst_x", X_out, 0);
    check("rst_y", Y_out, 0);
    check("rst_color", Color_out, 0);
    check("rst_we", writeEn, 0);
    check("rst_busy", busy, 0);
    check("rst_gid", grant_id, 0);
    check("rst_ready", ch_ready, 0);
    check("rst_done", ch_done, 0);
    resetn = 1'b0;

    // Fixed priority: ch0 and ch2 both request 3-beat packets
    for (int b = 0; b < 3; b++) begin
      load(0, b, 10 + b, 20, 12'h111, b == 2);
      load(2, b, 30 + b, 40, 12'h222, b == 2);
    end
    drive();
    for (int k = 1; k <= 10; k++) begin
      cyc();
      check($sformatf("fp_we_c%0d", k), writeEn, we_fp[k-1]);
      if (k == 1) begin
        check("fp_gid0", grant_id, 0);
        check("fp_busy_grant", busy, 1);
        check("fp_ready_bubble", ch_ready, 4'b0000);
      end
      if (k == 2) check("fp_ready_stream", ch_ready, 4'b0001);
      if (k == 5) begin
        check("fp_done0", ch_done, 4'b0001);
        check("fp_x_last0", X_out, 12);
        check("fp_busy_idle", busy, 0);
      end
      if (k == 6) begin
        check("fp_gid2", grant_id, 2);
        check("fp_done_clear", ch_done, 4'b0000);
      end
      if (k == 10) begin
        check("fp_done2", ch_done, 4'b0100);
        check("fp_x_last2", X_out, 32);
        check("fp_y_last2", Y_out, 40);
        check("fp_c_last2", Color_out, 12'h222);
      end
    end

    // Round-robin with every channel continuously offering single-beat packets
    do_reset();
    rr_mode = 1'b1;
    for (int i = 0; i < 4; i++)
      for (int b = 0; b < 2; b++)
        load(i, b, 50 + i, 60, 12'h333, 1'b1);
    drive();
    for (int k = 1; k <= 13; k++) begin
      cyc();
      if (k % 3 == 1) check($sformatf("rr_gid_%0d", k / 3), grant_id, rr_exp[k / 3]);
      if (k == 3) check("rr_done0", ch_done, 4'b0001);
      if (k == 6) check("rr_done1", ch_done, 4'b0010);
    end
    rr_mode = 1'b0;

    // Transparency on keyed ch1
    do_reset();
    key_en = 4'b0010;
    load(1, 0, 5, 5, 12'h000, 1'b0);
    load(1, 1, 6, 6, 12'hF00, 1'b1);
    drive();
    cyc(); cyc(); cyc();
    check("key1_we_black", writeEn, 0);
    check("key1_x_updates", X_out, 5);
    cyc();
    check("key1_we_red", writeEn, 1);
    check("key1_color", Color_out, 12'hF00);
    check("key1_done", ch_done, 4'b0010);

    // Same colours on unkeyed ch0
    do_reset();
    load(0, 0, 5, 5, 12'h000, 1'b0);
    load(0, 1, 6, 6, 12'hF00, 1'b1);
    drive();
    cyc(); cyc(); cyc();
    check("key0_we_black", writeEn, 1);
    cyc();
    check("key0_we_red", writeEn, 1);
    key_en = '0;

    // Clipping at the screen edges
    do_reset();
    load(0, 0, 320, 10, 12'hABC, 1'b0);
    load(0, 1, 319, 239, 12'hABC, 1'b0);
    load(0, 2, 5, 240, 12'hABC, 1'b1);
    drive();
    cyc(); cyc(); cyc();
    check("clip_x320_we", writeEn, 0);
    check("clip_x320_x", X_out, 320);
    cyc();
    check("clip_edge_we", writeEn, 1);
    check("clip_edge_x", X_out, 319);
    check("clip_edge_y", Y_out, 239);
    cyc();
    check("clip_y240_we", writeEn, 0);

    // Stall on ch3 mid-packet, then reset mid-packet
    do_reset();
    for (int b = 0; b < 4; b++)
      load(3, b, 100 + b, 50, 12'h0F0, b == 3);
    drive();
    cyc(); cyc(); cyc(); cyc();
    check("stall_pre_we", writeEn, 1);
    check("stall_pre_x", X_out, 101);
    stall = 4'b1000;
    drive();
    for (int s = 0; s < 3; s++) begin
      cyc();
      check($sformatf("stall_we_%0d", s), writeEn, 0);
      check($sformatf("stall_busy_%0d", s), busy, 1);
      check($sformatf("stall_gid_%0d", s), grant_id, 3);
      check($sformatf("stall_ready_%0d", s), ch_ready, 4'b1000);
    end
    stall = '0;
    drive();
    cyc();
    check("stall_resume_we", writeEn, 1);
    check("stall_resume_x", X_out, 102);
    resetn = 1'b1;
    #1;
    check("mid_rst_x", X_out, 0);
    check("mid_rst_y", Y_out, 0);
    check("mid_rst_color", Color_out, 0);
    check("mid_rst_we", writeEn, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_gid", grant_id, 0);
    check("mid_rst_ready", ch_ready, 0);
    check("mid_rst_done", ch_done, 0);

`ifdef DRAW_COMPOSITOR_STATS_EN
    do_reset();
    check("stats_rst_w", pix_written, 0);
    check("stats_rst_s", pix_suppressed, 0);
    key_en = 4'b0001;
    load(0, 0, 1, 1, 12'h001, 1'b0);
    load(0, 1, 2, 1, 12'h000, 1'b0);
    load(0, 2, 3, 1, 12'h002, 1'b0);
    load(0, 3, 4, 1, 12'h003, 1'b0);
    load(0, 4, 5, 1, 12'h000, 1'b0);
    load(0, 5, 6, 1, 12'h004, 1'b0);
    load(0, 6, 7, 1, 12'h005, 1'b1);
    drive();
    for (int k = 0; k < 12; k++) cyc();
    check("stats_written", pix_written, 5);
    check("stats_suppressed", pix_suppressed, 2);
    clear_stats = 1'b1;
    cyc();
    clear_stats = 1'b0;
    check("stats_clr_w", pix_written, 0);
    check("stats_clr_s", pix_suppressed, 0);
    key_en = '0;
`endif

    resetn = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/draw_compositor.md
Name: draw_compositor

Overview:
- N-channel pixel compositor that merges sprite/number/hook/background drawing streams into the single VGA write port (X_out, Y_out, Color_out, writeEn).
- Grants one channel per packet (a packet is one complete sprite draw) and locks that grant until the packet's last pixel is accepted.
- Applies per-channel colour-key transparency and screen clipping.
- Sits between the per-object draw datapaths and the VGA adapter; replaces ad-hoc if/else muxing with a parametrised, registered, handshaked block.

Parameters:
NUM_CH, 4, number of drawing channels (index 0 = highest fixed priority)
XW, 9, X coordinate width
YW, 8, Y coordinate width
CW, 12, colour width
SCREEN_W, 320, pixels with X >= SCREEN_W are clipped
SCREEN_H, 240, pixels with Y >= SCREEN_H are clipped
TRANSPARENT_KEY, 12'h000, colour treated as transparent on keyed channels

Ports:
clk  in  1  system clock, all logic on rising edge
resetn  in  1  asynchronous reset, active-high (asserted = 1); name kept per codebase convention
rr_mode  in  1  0 = fixed priority, 1 = round-robin; sampled only in IDLE
key_en  in  NUM_CH  bit i = 1 enables transparency on channel i
ch_valid  in  NUM_CH  channel i presents a pixel
ch_last  in  NUM_CH  channel i's current pixel is last of packet
ch_x  in  NUM_CH*XW  flattened X, channel i at [i*XW +: XW]
ch_y  in  NUM_CH*YW  flattened Y
ch_color  in  NUM_CH*CW  flattened colour
ch_ready  out  NUM_CH  one-hot accept to granted channel
ch_done  out  NUM_CH  one-cycle pulse, packet completed
X_out  out  XW  registered pixel X
Y_out  out  YW  registered pixel Y
Color_out  out  CW  registered pixel colour
writeEn  out  1  registered VGA write strobe
busy  out  1  high in GRANT or STREAM
grant_id  out  $clog2(NUM_CH)  currently/last granted channel

Behaviour:
- Reset (async, resetn=1): state IDLE, ch_ready=0, ch_done=0, X_out=0, Y_out=0, Color_out=0, writeEn=0, busy=0, grant_id=0, round-robin pointer=0.
- IDLE:
  - If any ch_valid bit is set, select the winner and go to GRANT.
  - Fixed priority: lowest index with ch_valid=1 wins.
  - Round-robin: first ch_valid=1 at or after the pointer, wrapping modulo NUM_CH.
  - grant_id is updated on the same edge.
- GRANT: one bubble cycle, ch_ready=0; go to STREAM.
- STREAM:
  - ch_ready[grant_id]=1; all other ch_ready bits are 0.
  - A beat is accepted when ch_valid[g] & ch_ready[g].
  - Beat accepted at cycle t → X_out/Y_out/Color_out show that beat at t+1.
  - writeEn=1 at t+1 unless the beat is suppressed.
  - Suppressed when (key_en[g] & color==TRANSPARENT_KEY), or x>=SCREEN_W, or y>=SCREEN_H.
  - The transparency test uses the incoming colour, never the registered Color_out.
  - On suppression, coordinates and colour still update; only writeEn=0.
- ch_valid[g] low during STREAM: no beat, writeEn=0 next cycle, grant held, no timeout.
- Accepted beat with ch_last[g]=1:
  - ch_done[g] pulses at t+1, coincident with the final pixel output.
  - State returns to IDLE at t+1; the round-robin pointer becomes (g+1) mod NUM_CH.
  - Earliest next grant decision is t+1 (IDLE), giving a 2-cycle gap between packets.
- Single-beat packet (ch_valid & ch_last on the first accepted beat): handled identically, ch_done at t+1.
- writeEn is 0 in every cycle without a beat accepted in the prior cycle.
- Ungranted channels hold their data; the compositor never drops a beat.
- rr_mode and key_en changes take effect at the next IDLE decision (key_en: at the next beat).
- Reset mid-packet: immediate return to reset values; the interrupted channel must restart its packet.
- NUM_CH=1: arbitration is trivial; the GRANT bubble is still present.

Optional Feature:
- Macro DRAW_COMPOSITOR_STATS_EN.
- When defined, adds:
  - Input clear_stats (1 bit).
  - Outputs pix_written[15:0] and pix_suppressed[15:0], incremented per accepted beat by outcome.
  - Counters saturate at 16'hFFFF.
  - Reset to 0 on resetn or clear_stats; clear_stats wins over a same-cycle increment.
- When undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Fixed priority: ch0 and ch2 valid together, 3-beat packets → ch0 streamed first, ch_done[0] pulses, then ch2 granted; writeEn pattern 0,0,1,1,1,0,0,1,1,1.
- Round-robin: rr_mode=1, all 4 channels continuously valid with single-beat packets → grant_id sequence 0,1,2,3,0.
- Transparency: key_en=4'b0010, ch1 colours 12'h000, 12'hF00 → writeEn 0 then 1. The same colours on ch0 (key off) → writeEn 1, 1.
- Clipping: beat x=320, y=10 → writeEn=0; beat x=319, y=239 → writeEn=1, X_out=319, Y_out=239.
- Stall and reset: ch3 drops ch_valid for 3 cycles mid-packet → writeEn 0 for those cycles, grant held. Asserting resetn mid-packet → all outputs 0, busy=0 in the same cycle.
- With DRAW_COMPOSITOR_STATS_EN: 5 written + 2 suppressed beats → pix_written=5, pix_suppressed=2; clear_stats → both 0.
